// File: rtl/seg7_pkg.sv
// Shared constants and hex decode for the multiplexed seven-segment driver.
// Segment patterns are active-low: bit 7 = DP, bits 6..0 = g..a.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam int         SEG_DP_BIT = 7;

  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] hex_to_seg(
    input logic [3:0] nibble,
    input logic       dp
  );
    logic [7:0] s;
    s = HEX_SEG[nibble];
    if (dp) s[SEG_DP_BIT] = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low segment pattern; a blanked digit keeps only its DP.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble, dp);
    if (blank) begin
      seg             = SEG_BLANK;
      seg[SEG_DP_BIT] = ~dp;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with leading-zero blanking and PWM
// brightness; all outputs registered, active-low.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int SCAN_DIV  = 16384,
  parameter int DUTY_BITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic [4*DIGITS-1:0]   i_data,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic                  i_blank_lz,
  input  logic [DUTY_BITS-1:0]  i_bright,
  output logic [7:0]            o_seg,
  output logic [DIGITS-1:0]     o_sel
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);

  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] DIGIT_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] SCAN_ONE   = CW'(1);
  localparam logic [IW-1:0] DIGIT_ONE  = IW'(1);

  logic [CW-1:0]          scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]          digit_idx_q, digit_idx_d;
  logic [4*DIGITS-1:0]    data_store_q, data_store_d;
  logic [DIGITS-1:0]      dp_store_q, dp_store_d;
  logic [7:0]             o_seg_q, o_seg_d;
  logic [DIGITS-1:0]      o_sel_q, o_sel_d;

  logic                   wrap;
  logic                   on_phase;
  logic                   hi_zero;
  logic                   blank;
  logic [3:0]             nibble;
  logic                   dp_bit;
  logic [7:0]             dec_seg;
  logic [DIGITS-1:0]      onehot;

  always_comb begin
    wrap        = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d  = wrap ? '0 : scan_cnt_q + SCAN_ONE;
    digit_idx_d = digit_idx_q;
    if (wrap) begin
      digit_idx_d = (digit_idx_q == DIGIT_LAST) ? '0
                  : digit_idx_q + DIGIT_ONE;
    end
    data_store_d = cs ? i_data : data_store_q;
    dp_store_d   = cs ? i_dp   : dp_store_q;
  end

  // Digit is a leading zero when it and every higher nibble are zero.
  always_comb begin
    nibble   = 4'(data_store_q >> {digit_idx_q, 2'b00});
    dp_bit   = dp_store_q[digit_idx_q];
    hi_zero  = ((data_store_q >> {digit_idx_q, 2'b00}) == '0);
    blank    = i_blank_lz && (digit_idx_q != '0) && hi_zero;
    on_phase = (scan_cnt_q[CW-1 -: DUTY_BITS] <= i_bright);
    onehot   = DIGITS'(1) << digit_idx_q;
  end

  seg7_decode u_decode (
    .nibble (nibble),
    .dp     (dp_bit),
    .blank  (blank),
    .seg    (dec_seg)
  );

  always_comb begin
    o_seg_d = SEG_BLANK;
    o_sel_d = '1;
    if (on_phase) begin
      o_seg_d = dec_seg;
      o_sel_d = ~onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q   <= '0;
      digit_idx_q  <= '0;
      data_store_q <= '0;
      dp_store_q   <= '0;
      o_seg_q      <= SEG_BLANK;
      o_sel_q      <= '1;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      digit_idx_q  <= digit_idx_d;
      data_store_q <= data_store_d;
      dp_store_q   <= dp_store_d;
      o_seg_q      <= o_seg_d;
      o_sel_q      <= o_sel_d;
    end
  end

  assign o_seg = o_seg_q;
  assign o_sel = o_sel_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: an 8-digit fast-scan instance and a
// 5-digit PWM instance share clock, reset, cs and blanking.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        blz;

  logic [31:0] a_data;
  logic [7:0]  a_dp;
  logic [1:0]  a_bright;
  logic [7:0]  a_seg;
  logic [7:0]  a_sel;

  logic [19:0] b_data;
  logic [4:0]  b_dp;
  logic [2:0]  b_bright;
  logic [7:0]  b_seg;
  logic [4:0]  b_sel;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIGITS    (8),
    .SCAN_DIV  (4),
    .DUTY_BITS (2)
  ) u_a (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .i_data     (a_data),
    .i_dp       (a_dp),
    .i_blank_lz (blz),
    .i_bright   (a_bright),
    .o_seg      (a_seg),
    .o_sel      (a_sel)
  );

  seg7_scan_ctrl #(
    .DIGITS    (5),
    .SCAN_DIV  (8),
    .DUTY_BITS (3)
  ) u_b (
    .clk        (clk),
    .reset      (reset),
    .cs         (cs),
    .i_data     (b_data),
    .i_dp       (b_dp),
    .i_blank_lz (blz),
    .i_bright   (b_bright),
    .o_seg      (b_seg),
    .o_sel      (b_sel)
  );

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  // cyc counts non-reset edges since the last reset edge.
  task automatic tick();
    @(posedge clk);
    if (reset) cyc = 0;
    else cyc++;
    @(negedge clk);
  endtask

  task automatic load_a(input logic [31:0] d, input logic [7:0] dp);
    a_data = d;
    a_dp   = dp;
    cs     = 1'b1;
    tick();
    cs = 1'b0;
    tick();
  endtask

  task automatic frame_a(input string tag, input logic [7:0][7:0] e,
                         input int n);
    int p;
    int d;
    logic [7:0] sel;
    for (int i = 0; i < n; i++) begin
      tick();
      p   = cyc - 1;
      d   = (p / 4) % 8;
      sel = ~(8'd1 << d);
      check({tag, "_sel"}, 16'(a_sel), 16'(sel));
      check({tag, "_seg"}, 16'(a_seg), 16'(e[d]));
    end
  endtask

  task automatic frame_b(input string tag, input logic [4:0][7:0] e,
                         input int br, input int n);
    int p;
    int d;
    int ph;
    logic [4:0] sel;
    logic [7:0] seg;
    for (int i = 0; i < n; i++) begin
      tick();
      p  = cyc - 1;
      d  = (p / 8) % 5;
      ph = p % 8;
      if (ph <= br) begin
        sel = ~(5'd1 << d);
        seg = e[d];
      end else begin
        sel = 5'h1F;
        seg = 8'hFF;
      end
      check({tag, "_sel"}, 16'(b_sel), 16'(sel));
      check({tag, "_seg"}, 16'(b_seg), 16'(seg));
    end
  endtask

  initial begin
    reset    = 1'b1;
    cs       = 1'b0;
    blz      = 1'b0;
    a_data   = '0;
    a_dp     = '0;
    a_bright = 2'd3;
    b_data   = '0;
    b_dp     = '0;
    b_bright = 3'd7;
    @(negedge clk);
    tick();
    tick();
    check("rst_a_seg", 16'(a_seg), 16'h00FF);
    check("rst_a_sel", 16'(a_sel), 16'h00FF);
    check("rst_b_seg", 16'(b_seg), 16'h00FF);
    check("rst_b_sel", 16'(b_sel), 16'h001F);

    reset  = 1'b0;
    cs     = 1'b1;
    a_data = 32'h0123_4567;
    b_data = 20'h43210;
    tick();
    cs = 1'b0;
    check("first_seg", 16'(a_seg), 16'h00C0);
    check("first_sel", 16'(a_sel), 16'h00FE);
    frame_a("hex", {8'hC0, 8'hF9, 8'hA4, 8'hB0,
                    8'h99, 8'h92, 8'h82, 8'hF8}, 32);

    load_a(32'h0123_4567, 8'h81);
    frame_a("dp", {8'h40, 8'hF9, 8'hA4, 8'hB0,
                   8'h99, 8'h92, 8'h82, 8'h78}, 32);

    blz = 1'b1;
    load_a(32'h0000_00A0, 8'h00);
    frame_a("lz_a0", {8'hFF, 8'hFF, 8'hFF, 8'hFF,
                      8'hFF, 8'hFF, 8'h88, 8'hC0}, 32);

    load_a(32'h0000_1000, 8'h00);
    frame_a("lz_mid", {8'hFF, 8'hFF, 8'hFF, 8'hFF,
                       8'hF9, 8'hC0, 8'hC0, 8'hC0}, 32);

    load_a(32'h0000_0000, 8'h00);
    frame_a("lz_zero", {8'hFF, 8'hFF, 8'hFF, 8'hFF,
                        8'hFF, 8'hFF, 8'hFF, 8'hC0}, 32);

    load_a(32'h0000_0000, 8'h04);
    frame_a("lz_dp", {8'hFF, 8'hFF, 8'hFF, 8'hFF,
                      8'hFF, 8'h7F, 8'hFF, 8'hC0}, 32);

    // Load lands on the edge that moves digit 2 to digit 3.
    blz = 1'b0;
    load_a(32'h0123_4567, 8'h00);
    for (int i = 0; i < 32 && (cyc % 32) != 11; i++) tick();
    cs     = 1'b1;
    a_data = 32'hFEDC_BA98;
    tick();
    cs = 1'b0;
    check("wrap_old_seg", 16'(a_seg), 16'h0092);
    check("wrap_old_sel", 16'(a_sel), 16'h00FB);
    tick();
    check("wrap_new_seg", 16'(a_seg), 16'h0083);
    check("wrap_new_sel", 16'(a_sel), 16'h00F7);

    // Reset in the middle of digit 3's slot.
    for (int i = 0; i < 32 && (cyc % 32) != 13; i++) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_seg", 16'(a_seg), 16'h00FF);
    check("mid_rst_sel", 16'(a_sel), 16'h00FF);
    check("mid_rst_bsel", 16'(b_sel), 16'h001F);
    reset = 1'b0;
    tick();
    check("post_rst_seg", 16'(a_seg), 16'h00C0);
    check("post_rst_sel", 16'(a_sel), 16'h00FE);
    frame_a("cleared", {8'hC0, 8'hC0, 8'hC0, 8'hC0,
                        8'hC0, 8'hC0, 8'hC0, 8'hC0}, 32);

    b_data   = 20'h43210;
    b_dp     = 5'h00;
    b_bright = 3'd7;
    cs       = 1'b1;
    tick();
    cs = 1'b0;
    tick();
    frame_b("b_full", {8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}, 7, 48);
    b_bright = 3'd1;
    frame_b("b_pwm1", {8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}, 1, 48);
    b_bright = 3'd0;
    frame_b("b_pwm0", {8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}, 0, 48);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment display driver: the successor to the fixed 8-digit hex scanner used on the board top level. It latches a DIGITS-wide hex word plus per-digit decimal points on a load strobe, scans the digits at a configurable rate, and adds leading-zero blanking and PWM brightness control. Segment and select outputs are active-low and drive the board display directly. It sits between the CPU debug/PC tap and the display pins.

## Interface
- DIGITS, 8: number of digits scanned; legal range 2..16.
- SCAN_DIV, 16384: clk cycles per digit slot; power of two, ≥ 2**DUTY_BITS.
- DUTY_BITS, 3: brightness resolution in bits.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- cs  in  1  load strobe; latches i_data, i_dp.
- i_data  in  4*DIGITS  hex nibbles; nibble k is digit k, digit 0 rightmost.
- i_dp  in  DIGITS  decimal-point request per digit, 1 = lit.
- i_blank_lz  in  1  leading-zero suppression enable; sampled live.
- i_bright  in  DUTY_BITS  brightness level; sampled live.
- o_seg  out  8  segments, active-low; bit 7 = DP, bits 6..0 = g..a.
- o_sel  out  DIGITS  digit enables, active-low, at most one low.

## Operation
- Registers: scan_cnt (log2 SCAN_DIV bits), digit_idx (clog2 DIGITS bits), data_store, dp_store, o_seg_r, o_sel_r.
- Reset (synchronous, on clk edge with reset=1): scan_cnt=0, digit_idx=0, data_store=0, dp_store=0, o_seg=8'hFF, o_sel=all ones. Reset has priority over cs and scan advance; reset mid-scan restarts at digit 0.
- scan_cnt increments every cycle, wraps at SCAN_DIV-1 to 0; on wrap digit_idx increments, wrapping DIGITS-1 → 0 (non-power-of-two DIGITS wraps explicitly, never visits illegal indices).
- cs=1: data_store ← i_data, dp_store ← i_dp on that edge. cs held high reloads every cycle. cs coinciding with digit advance: both take effect; no special case.
- Hex decode (active-low): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E. DP lit clears bit 7.
- Leading-zero blanking: when i_blank_lz=1, digit k (k ≥ 1) is blanked if nibbles k..DIGITS-1 of data_store are all zero. Digit 0 never blanked. Blanked digit segments = 8'hFF, except DP still honoured (8'h7F if dp_store[k]).
- Brightness: on-phase when scan_cnt[MSB -: DUTY_BITS] ≤ i_bright. On-phase: o_sel = one-hot-low at digit_idx. Off-phase: o_sel all ones, o_seg = 8'hFF. i_bright = all ones → 100% duty; 0 → 1/2**DUTY_BITS.

## Timing
- All outputs registered; no combinational path input → output.
- o_seg/o_sel at edge t+1 reflect digit_idx, scan_cnt, stores, i_blank_lz, i_bright at edge t (1-cycle latency); o_seg and o_sel always change on the same edge, never mismatched.
- cs at edge t → data_store at t+1 → o_seg at t+2.
- First output after reset release: digit 0 selected one cycle after the first non-reset edge.
- Full refresh period = DIGITS × SCAN_DIV cycles.

## Structure
- Package seg7_pkg: 16-entry hex→segment constant table, SEG_BLANK = 8'hFF, SEG_DP_BIT = 7, function hex_to_seg(nibble, dp).
- One combinational sub-module seg7_decode (nibble, dp, blank → 8-bit active-low pattern); top holds counters, stores, blanking and PWM logic.

## Test plan
- Reset then DIGITS=8, SCAN_DIV=4, cs with i_data=32'h0123_4567, i_bright=7 → o_sel cycles FE,FD,…,7F, each held 4 cycles; o_seg 92/92.. i.e. digit0 F8, digit1 82, digit7 C0.
- Same data, i_blank_lz=1, i_data=32'h0000_00A0 → digits 2..7 o_seg=FF, digit1 88, digit0 C0; i_data=0 → only digit 0 shows C0.
- i_dp=8'h04 with i_data=0, blanking on → digit 2 o_seg=7F, digit 0 C0, others FF.
- SCAN_DIV=8, DUTY_BITS=3, i_bright=1 → per slot o_sel low 2 cycles, high 6; i_bright=0 → 1 cycle low.
- cs on the exact wrap edge with new data → o_seg of next digit shows new value 2 cycles after cs; DIGITS=5 → idx sequence 0..4,0, never 5.
- reset asserted mid-slot on digit 3 → next edge o_seg=FF, o_sel=all ones, stores cleared; after release digit 0 shows C0.
